// File: rtl/mode_desk_pkg.sv
// Shared constants and types for the organ-desk mode controller.
// Mode indices name the four operating modes; bus widths size the per-mode slices.
package mode_desk_pkg;

    localparam int unsigned MODE_SELECT = 0;
    localparam int unsigned MODE_FREE   = 1;
    localparam int unsigned MODE_AUTO   = 2;
    localparam int unsigned MODE_STUDY  = 3;

    localparam int unsigned AN_W  = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned LED_W = 7;

    // One mode's worth of board-facing outputs.
    typedef struct packed {
        logic             pwm;
        logic [AN_W-1:0]  an;
        logic [SEG_W-1:0] light;
        logic [LED_W-1:0] ledlight;
    } out_bus_t;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: 2-FF synchroniser, hold counter, stable level and
// a one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
    parameter int unsigned CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Level flips on the CYCLES-th consecutive differing sample.
            if (sync2 != level) begin
                if (cnt == CNT_W'(CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mode_desk_ctrl.sv
// Organ-desk mode controller: debounced buttons step through enabled modes,
// pick a song in the song mode, and register the active mode's board buses.
module mode_desk_ctrl
    import mode_desk_pkg::*;
#(
    parameter int unsigned NUM_MODES       = 4,
    parameter int unsigned NUM_SONGS       = 3,
    parameter int unsigned SONG_MODE       = MODE_AUTO,
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    localparam int unsigned MODE_W         = idx_width(NUM_MODES),
    localparam int unsigned SONG_W         = idx_width(NUM_SONGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        left,
    input  logic                        right,
    input  logic                        up,
    input  logic                        down,
    input  logic [NUM_MODES-1:0]        mode_en,
    input  logic [NUM_MODES-1:0]        mode_pwm,
    input  logic [AN_W*NUM_MODES-1:0]   mode_an,
    input  logic [SEG_W*NUM_MODES-1:0]  mode_light,
    input  logic [LED_W*NUM_MODES-1:0]  mode_ledlight,
    output logic                        pwm,
    output logic [AN_W-1:0]             an,
    output logic [SEG_W-1:0]            light,
    output logic [LED_W-1:0]            ledlight,
    output logic [MODE_W-1:0]           mode,
    output logic [SONG_W-1:0]           song_sel,
    output logic                        mode_chg,
    output logic                        song_chg
);

    logic [3:0] raw;
    logic [3:0] press;
    logic       left_p, right_p, up_p, down_p;

    assign raw = {down, up, right, left};

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[g]),
            .press (press[g])
        );
    end

    assign left_p  = press[0];
    assign right_p = press[1];
    assign up_p    = press[2];
    assign down_p  = press[3];

    function automatic logic [MODE_W-1:0] wrap_mode(input int v);
        return MODE_W'((v >= int'(NUM_MODES)) ? v - int'(NUM_MODES) : v);
    endfunction

    logic [NUM_MODES-1:0]   en_eff;
    logic [NUM_MODES-2:0]   rot;
    logic                   up_found, dn_found;
    logic [MODE_W-1:0]      up_idx, dn_idx;
    logic [MODE_W-1:0]      mode_nxt;
    logic                   mode_chg_nxt;
    logic [SONG_W-1:0]      song_nxt;
    logic                   song_chg_nxt;
    out_bus_t               sel_bus;
    out_bus_t               out_q;

    // rot[k] is the enable of mode (mode+1+k) mod NUM_MODES, so the upward
    // search scans rot from the bottom and the downward search from the top.
    always_comb begin
        en_eff   = mode_en | NUM_MODES'(1);
        rot      = (NUM_MODES-1)'({en_eff, en_eff} >> (int'(mode) + 1));
        up_found = 1'b0;
        dn_found = 1'b0;
        up_idx   = mode;
        dn_idx   = mode;
        for (int k = 0; k < int'(NUM_MODES) - 1; k++) begin
            if (!up_found && rot[k]) begin
                up_found = 1'b1;
                up_idx   = wrap_mode(int'(mode) + 1 + k);
            end
            if (!dn_found && rot[int'(NUM_MODES) - 2 - k]) begin
                dn_found = 1'b1;
                dn_idx   = wrap_mode(int'(mode) + int'(NUM_MODES) - 1 - k);
            end
        end
    end

    always_comb begin
        mode_nxt     = mode;
        mode_chg_nxt = 1'b0;
        if (right_p && !left_p && up_found) begin
            mode_nxt     = up_idx;
            mode_chg_nxt = 1'b1;
        end else if (left_p && !right_p && dn_found) begin
            mode_nxt     = dn_idx;
            mode_chg_nxt = 1'b1;
        end
    end

    // Song keys are judged against the registered mode, before any same-cycle mode step.
    always_comb begin
        song_nxt     = song_sel;
        song_chg_nxt = 1'b0;
        if (mode == MODE_W'(SONG_MODE) && (up_p ^ down_p)) begin
            song_chg_nxt = 1'b1;
            if (up_p) begin
                song_nxt = (song_sel == SONG_W'(NUM_SONGS - 1)) ? '0 : song_sel + 1'b1;
            end else begin
                song_nxt = (song_sel == '0) ? SONG_W'(NUM_SONGS - 1) : song_sel - 1'b1;
            end
        end
    end

    always_comb begin
        sel_bus = '0;
        for (int i = 0; i < int'(NUM_MODES); i++) begin
            if (mode == MODE_W'(i)) begin
                sel_bus.pwm      = mode_pwm[i];
                sel_bus.an       = mode_an[i*AN_W +: AN_W];
                sel_bus.light    = mode_light[i*SEG_W +: SEG_W];
                sel_bus.ledlight = mode_ledlight[i*LED_W +: LED_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= '0;
            mode_chg <= 1'b0;
            song_sel <= '0;
            song_chg <= 1'b0;
            out_q    <= '0;
        end else begin
            mode     <= mode_nxt;
            mode_chg <= mode_chg_nxt;
            song_sel <= song_nxt;
            song_chg <= song_chg_nxt;
            out_q    <= sel_bus;
        end
    end

    assign pwm      = out_q.pwm;
    assign an       = out_q.an;
    assign light    = out_q.light;
    assign ledlight = out_q.ledlight;

endmodule
